// File: rtl/fir8_tap_accumulator_if.sv
// Bus bundle for fir8_tap_accumulator: product-set input, coefficient write port
// and valid/ready sample output. The slave modport is the accumulator side.
interface fir8_if #(
    parameter int unsigned PROD_W = 12,
    parameter int unsigned OUT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_data1;
    logic [PROD_W-1:0] in_data2;
    logic [PROD_W-1:0] in_data3;
    logic [PROD_W-1:0] in_data4;
    logic [PROD_W-1:0] in_data5;
    logic [PROD_W-1:0] in_data6;
    logic [PROD_W-1:0] in_data7;
    logic [PROD_W-1:0] in_data8;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic [4:0]        coef_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport master (
        output in_valid, in_data1, in_data2, in_data3, in_data4,
               in_data5, in_data6, in_data7, in_data8,
               coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data1, in_data2, in_data3, in_data4,
               in_data5, in_data6, in_data7, in_data8,
               coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir8_tap_accumulator.sv
// 8-tap transposed-form FIR over pre-split odd-multiple products, with a 2-entry output FIFO.
// Optional macro FIR_SAT_EN clamps the output sample to the signed OUT_W range.
module fir8_tap_accumulator #(
    parameter int unsigned PROD_W = 12,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned OUT_W  = 16
) (
    input  logic    clk,
    input  logic    rst,
    fir8_if.slave   bus
);
    localparam int unsigned NTAP = 8;

    logic [PROD_W-1:0]       prod  [NTAP];
    logic [4:0]              coef  [NTAP];
    logic signed [ACC_W-1:0] term  [NTAP];
    logic signed [ACC_W-1:0] z     [NTAP-1];
    logic signed [ACC_W-1:0] y;
    logic [OUT_W-1:0]        y_out;
    logic [OUT_W-1:0]        mem   [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic                    accept;
    logic                    pop;

    assign prod[0] = bus.in_data1;
    assign prod[1] = bus.in_data2;
    assign prod[2] = bus.in_data3;
    assign prod[3] = bus.in_data4;
    assign prod[4] = bus.in_data5;
    assign prod[5] = bus.in_data6;
    assign prod[6] = bus.in_data7;
    assign prod[7] = bus.in_data8;

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = mem[rd_ptr];
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Tap term: selected product, zero-extended, optionally negated, gated by enable
    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            term[k] = '0;
            if (coef[k][4]) begin
                term[k] = coef[k][3] ? -ACC_W'(prod[coef[k][2:0]]) : ACC_W'(prod[coef[k][2:0]]);
            end
        end
    end

    assign y = term[0] + z[0];

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        y_out = OUT_W'(y);
        if (y > SAT_MAX) begin
            y_out = OUT_W'(SAT_MAX);
        end else if (y < SAT_MIN) begin
            y_out = OUT_W'(SAT_MIN);
        end
    end
`else
    assign y_out = y[OUT_W-1:0];
`endif

    // Coefficients, delay line and output FIFO; the delay line only advances on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAP; k++) begin
                coef[k] <= (k == 0) ? 5'b1_0_000 : 5'b0_0_000;
            end
            for (int k = 0; k < NTAP - 1; k++) begin
                z[k] <= '0;
            end
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (bus.coef_we) begin
                coef[bus.coef_addr] <= bus.coef_data;
            end
            if (accept) begin
                for (int k = 0; k < NTAP - 2; k++) begin
                    z[k] <= term[k+1] + z[k+1];
                end
                z[NTAP-2]   <= term[NTAP-1];
                mem[wr_ptr] <= y_out;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fir8_tap_accumulator.sv
// Directed bench for fir8_tap_accumulator: a 16-bit output instance plus a 12-bit
// output instance sharing the same stimulus (overflow/saturation case).
module tb_fir8_tap_accumulator;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fir8_if #(.PROD_W(12), .OUT_W(16)) bus16 ();
    fir8_if #(.PROD_W(12), .OUT_W(12)) bus12 ();

    fir8_tap_accumulator #(.PROD_W(12), .ACC_W(16), .OUT_W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    fir8_tap_accumulator #(.PROD_W(12), .ACC_W(16), .OUT_W(12)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    assign bus12.in_valid  = bus16.in_valid;
    assign bus12.in_data1  = bus16.in_data1;
    assign bus12.in_data2  = bus16.in_data2;
    assign bus12.in_data3  = bus16.in_data3;
    assign bus12.in_data4  = bus16.in_data4;
    assign bus12.in_data5  = bus16.in_data5;
    assign bus12.in_data6  = bus16.in_data6;
    assign bus12.in_data7  = bus16.in_data7;
    assign bus12.in_data8  = bus16.in_data8;
    assign bus12.coef_we   = bus16.coef_we;
    assign bus12.coef_addr = bus16.coef_addr;
    assign bus12.coef_data = bus16.coef_data;
    assign bus12.out_ready = bus16.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_x(input int x);
        bus16.in_data1 = 12'(1 * x);
        bus16.in_data2 = 12'(3 * x);
        bus16.in_data3 = 12'(5 * x);
        bus16.in_data4 = 12'(7 * x);
        bus16.in_data5 = 12'(9 * x);
        bus16.in_data6 = 12'(11 * x);
        bus16.in_data7 = 12'(13 * x);
        bus16.in_data8 = 12'(15 * x);
    endtask

    task automatic wcoef(input int k, input logic [4:0] d);
        bus16.coef_we   = 1'b1;
        bus16.coef_addr = 3'(k);
        bus16.coef_data = d;
        cyc();
        bus16.coef_we   = 1'b0;
    endtask

    initial begin
        int exp_imp [9];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.coef_we   = 1'b0;
        bus16.coef_addr = 3'd0;
        bus16.coef_data = 5'd0;
        bus16.out_ready = 1'b1;
        set_x(0);
        cyc();
        cyc();
        rst = 1'b0;

        // T1 reset state and passthrough
        chk("rst_in_ready", 32'(bus16.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus16.out_data), 32'd0);
        set_x(100);
        bus16.in_valid = 1'b1;
        cyc();
        bus16.in_valid = 1'b0;
        chk("t1_valid", 32'(bus16.out_valid), 32'd1);
        chk("t1_data", 32'(bus16.out_data), 32'd100);
        cyc();
        chk("t1_drain", 32'(bus16.out_valid), 32'd0);

        // T2 impulse response with tap k selecting product k
        for (int k = 0; k < 8; k++) wcoef(k, {2'b10, 3'(k)});
        exp_imp = '{1, 3, 5, 7, 9, 11, 13, 15, 0};
        bus16.in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_x(i == 0 ? 1 : 0);
            cyc();
            chk($sformatf("t2_valid%0d", i), 32'(bus16.out_valid), 32'd1);
            chk($sformatf("t2_data%0d", i), 32'(bus16.out_data), 32'(exp_imp[i]));
        end
        bus16.in_valid = 1'b0;
        cyc();
        chk("t2_drain", 32'(bus16.out_valid), 32'd0);

        // T3 backpressure: x=1,2,3 through impulse coefs -> 1, 5, 14
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1;
        set_x(1);
        cyc();
        chk("t3_rdy_a", 32'(bus16.in_ready), 32'd1);
        chk("t3_head_a", 32'(bus16.out_data), 32'd1);
        set_x(2);
        cyc();
        chk("t3_rdy_full", 32'(bus16.in_ready), 32'd0);
        set_x(3);
        cyc();
        cyc();
        chk("t3_rdy_hold", 32'(bus16.in_ready), 32'd0);
        chk("t3_head_hold", 32'(bus16.out_data), 32'd1);
        chk("t3_valid_hold", 32'(bus16.out_valid), 32'd1);
        bus16.out_ready = 1'b1;
        cyc();
        chk("t3_second", 32'(bus16.out_data), 32'd5);
        cyc();
        bus16.in_valid = 1'b0;
        chk("t3_third", 32'(bus16.out_data), 32'd14);
        chk("t3_third_v", 32'(bus16.out_valid), 32'd1);
        cyc();
        chk("t3_drain", 32'(bus16.out_valid), 32'd0);

        // T6 mid-stream reset with FIFO full and delay line loaded
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1;
        set_x(1);
        cyc();
        cyc();
        bus16.in_valid = 1'b0;
        chk("t6_full", 32'(bus16.in_ready), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("t6_in_ready", 32'(bus16.in_ready), 32'd1);
        bus16.out_ready = 1'b1;
        bus16.in_valid  = 1'b1;
        set_x(7);
        cyc();
        chk("t6_x7", 32'(bus16.out_data), 32'd7);
        set_x(0);
        cyc();
        bus16.in_valid = 1'b0;
        chk("t6_coef_reset", 32'(bus16.out_data), 32'd0);
        cyc();
        chk("t6_drain", 32'(bus16.out_valid), 32'd0);

        // T4 negated x*15 for x=255
        wcoef(0, 5'b1_1_111);
        set_x(255);
        bus16.in_valid = 1'b1;
        cyc();
        bus16.in_valid = 1'b0;
        chk("t4_neg", 32'(bus16.out_data), 32'h0000_F10F);
        cyc();
        chk("t4_drain", 32'(bus16.out_valid), 32'd0);

        // T5 all taps +x*15, x=255 held: ramp of 3825 steps to 30600
        for (int k = 0; k < 8; k++) wcoef(k, 5'b1_0_111);
        bus16.in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk($sformatf("t5_acc%0d", i), 32'(bus16.out_data), 32'((i < 8 ? i + 1 : 8) * 3825));
        end
`ifdef FIR_SAT_EN
        chk("t5_out12", 32'(bus12.out_data), 32'h7FF);
`else
        chk("t5_out12", 32'(bus12.out_data), 32'h788);
`endif

        // Same-cycle coef write and accept uses the old code
        bus16.coef_we   = 1'b1;
        bus16.coef_addr = 3'd0;
        bus16.coef_data = 5'b1_0_000;
        cyc();
        bus16.coef_we = 1'b0;
        chk("wr_old_code", 32'(bus16.out_data), 32'd30600);
        cyc();
        bus16.in_valid = 1'b0;
        chk("wr_new_code", 32'(bus16.out_data), 32'd27030);
        cyc();
        chk("final_drain", 32'(bus16.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
